// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-tick majority vote per bit,
// false-start rejection, optional parity, 1 or 2 stop bits and break detection.
module uart_rx_param #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_bd,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dataout,
    output logic                 rdsig,
    output logic                 dataerror,
    output logic                 frameerror,
    output logic                 brk,
    output logic                 busy
);

    localparam int unsigned TC_W = $clog2(OVERSAMPLE);
    localparam int unsigned BI_W = $clog2(DATA_BITS);
    localparam int unsigned MID  = OVERSAMPLE / 2;

    localparam logic [TC_W-1:0] TC_LO   = TC_W'(MID - 1);
    localparam logic [TC_W-1:0] TC_MID  = TC_W'(MID);
    localparam logic [TC_W-1:0] TC_HI   = TC_W'(MID + 1);
    localparam logic [TC_W-1:0] TC_END  = TC_W'(OVERSAMPLE - 1);
    localparam logic [BI_W-1:0] BI_LAST = BI_W'(DATA_BITS - 1);
    localparam logic            SI_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                state, state_nxt;
    logic                  rx_s1, rxs;
    logic [TC_W-1:0]       tc, tc_nxt;
    logic [BI_W-1:0]       bit_idx, bit_idx_nxt;
    logic                  stop_idx, stop_idx_nxt;
    logic [DATA_BITS-1:0]  shreg, shreg_nxt;
    logic                  smp_lo, smp_lo_nxt;
    logic                  smp_mid, smp_mid_nxt;
    logic                  par_bit, par_bit_nxt;
    logic                  par_err, par_err_nxt;
    logic                  frm_err, frm_err_nxt;
    logic                  stop0, stop0_nxt;
    logic                  maj_c;
    logic                  exp_par_c;
    logic                  first_stop_c;
    logic                  frm_c;
    logic                  brk_c;
    logic                  done_c;
    logic                  at_hi_c;
    logic                  at_end_c;

    // Vote over the two stored samples and the live sample on the MID+1 tick
    assign maj_c     = (smp_lo & smp_mid) | (smp_lo & rxs) | (smp_mid & rxs);
    assign exp_par_c = (PARITY_MODE == 1) ? ^shreg : ~^shreg;
    assign at_hi_c   = (tc == TC_HI);
    assign at_end_c  = (tc == TC_END);

    // State, counters and frame datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1      <= 1'b1;
            rxs        <= 1'b1;
            state      <= S_IDLE;
            tc         <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            smp_lo     <= 1'b0;
            smp_mid    <= 1'b0;
            par_bit    <= 1'b0;
            par_err    <= 1'b0;
            frm_err    <= 1'b0;
            stop0      <= 1'b0;
            dataout    <= '0;
            rdsig      <= 1'b0;
            dataerror  <= 1'b0;
            frameerror <= 1'b0;
            brk        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rxs      <= rx_s1;
            state    <= state_nxt;
            tc       <= tc_nxt;
            bit_idx  <= bit_idx_nxt;
            stop_idx <= stop_idx_nxt;
            shreg    <= shreg_nxt;
            smp_lo   <= smp_lo_nxt;
            smp_mid  <= smp_mid_nxt;
            par_bit  <= par_bit_nxt;
            par_err  <= par_err_nxt;
            frm_err  <= frm_err_nxt;
            stop0    <= stop0_nxt;
            rdsig    <= done_c;
            busy     <= (state_nxt != S_IDLE);
            if (done_c) begin
                dataout    <= shreg;
                dataerror  <= par_err;
                frameerror <= frm_c;
                brk        <= brk_c;
            end
        end
    end

    // Next-state and datapath update; nothing moves without a baud tick
    always_comb begin
        state_nxt    = state;
        tc_nxt       = tc;
        bit_idx_nxt  = bit_idx;
        stop_idx_nxt = stop_idx;
        shreg_nxt    = shreg;
        smp_lo_nxt   = smp_lo;
        smp_mid_nxt  = smp_mid;
        par_bit_nxt  = par_bit;
        par_err_nxt  = par_err;
        frm_err_nxt  = frm_err;
        stop0_nxt    = stop0;
        first_stop_c = stop_idx ? stop0 : maj_c;
        frm_c        = frm_err;
        brk_c        = 1'b0;
        done_c       = 1'b0;

        if (clk_bd) begin
            if (state != S_IDLE && state != S_WAIT_HIGH) begin
                tc_nxt = at_end_c ? '0 : tc + TC_W'(1);
                if (tc == TC_LO) begin
                    smp_lo_nxt = rxs;
                end
                if (tc == TC_MID) begin
                    smp_mid_nxt = rxs;
                end
            end

            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state_nxt   = S_START;
                        tc_nxt      = '0;
                        par_bit_nxt = 1'b0;
                        par_err_nxt = 1'b0;
                        frm_err_nxt = 1'b0;
                        stop0_nxt   = 1'b0;
                    end
                end
                S_START: begin
                    if (at_hi_c && maj_c) begin
                        state_nxt = S_IDLE;
                    end else if (at_end_c) begin
                        state_nxt   = S_DATA;
                        bit_idx_nxt = '0;
                    end
                end
                S_DATA: begin
                    if (at_hi_c) begin
                        shreg_nxt = {maj_c, shreg[DATA_BITS-1:1]};
                    end
                    if (at_end_c) begin
                        if (bit_idx == BI_LAST) begin
                            state_nxt    = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                            stop_idx_nxt = 1'b0;
                        end else begin
                            bit_idx_nxt = bit_idx + BI_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (at_hi_c) begin
                        par_bit_nxt = maj_c;
                        par_err_nxt = (maj_c != exp_par_c);
                    end
                    if (at_end_c) begin
                        state_nxt    = S_STOP;
                        stop_idx_nxt = 1'b0;
                    end
                end
                S_STOP: begin
                    if (at_hi_c) begin
                        frm_c       = frm_err | ~maj_c;
                        frm_err_nxt = frm_c;
                        if (!stop_idx) begin
                            stop0_nxt = maj_c;
                        end
                        // Completion does not wait for the bit end, so back-to-back frames are caught
                        if (stop_idx == SI_LAST) begin
                            done_c    = 1'b1;
                            brk_c     = ~|shreg & ~par_bit & ~first_stop_c;
                            state_nxt = brk_c ? S_WAIT_HIGH : S_IDLE;
                        end
                    end else if (at_end_c) begin
                        stop_idx_nxt = 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rxs) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four differently configured receivers, frames built from
// their bit-level definition, expected results queued and checked on every rdsig.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_bd;
    logic [3:0] rx_v;
    logic [7:0] dout0, dout1, dout2;
    logic [6:0] dout3;
    logic [3:0] rd_v, de_v, fe_v, bk_v, bs_v;
    logic [3:0] prev_rd = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    exp_t q[4][$];

    always #5 clk = ~clk;

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .clk_bd(clk_bd), .rx(rx_v[0]), .dataout(dout0),
        .rdsig(rd_v[0]), .dataerror(de_v[0]), .frameerror(fe_v[0]), .brk(bk_v[0]), .busy(bs_v[0]));
    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clk_bd(clk_bd), .rx(rx_v[1]), .dataout(dout1),
        .rdsig(rd_v[1]), .dataerror(de_v[1]), .frameerror(fe_v[1]), .brk(bk_v[1]), .busy(bs_v[1]));
    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(2), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .clk_bd(clk_bd), .rx(rx_v[2]), .dataout(dout2),
        .rdsig(rd_v[2]), .dataerror(de_v[2]), .frameerror(fe_v[2]), .brk(bk_v[2]), .busy(bs_v[2]));
    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY_MODE(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .clk_bd(clk_bd), .rx(rx_v[3]), .dataout(dout3),
        .rdsig(rd_v[3]), .dataerror(de_v[3]), .frameerror(fe_v[3]), .brk(bk_v[3]), .busy(bs_v[3]));

    function automatic int db(input int k);
        return (k == 3) ? 7 : 8;
    endfunction

    function automatic int os(input int k);
        return (k == 3) ? 8 : 16;
    endfunction

    function automatic int pm(input int k);
        return (k == 1) ? 1 : (k == 2) ? 2 : 0;
    endfunction

    function automatic int sb(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    function automatic logic [8:0] dout_of(input int k);
        case (k)
            0:       return {1'b0, dout0};
            1:       return {1'b0, dout1};
            2:       return {1'b0, dout2};
            default: return {2'b00, dout3};
        endcase
    endfunction

    function automatic logic [8:0] mask_data(input int k, input logic [8:0] data);
        int m;
        m = (1 << db(k)) - 1;
        return data & 9'(m);
    endfunction

    // Parity bit a correct transmitter would send for this receiver's mode
    function automatic logic good_par(input int k, input logic [8:0] data);
        logic ones;
        ones = ^mask_data(k, data);
        return (pm(k) == 2) ? ~ones : ones;
    endfunction

    // Expected receiver verdict for a frame, straight from the framing rules
    function automatic exp_t model(input int k, input logic [8:0] data, input logic pbit,
                                   input logic [1:0] stops);
        exp_t e;
        logic [8:0] d;
        logic ones;
        d      = mask_data(k, data);
        ones   = ^d;
        e.data = d;
        if (pm(k) == 0)      e.perr = 1'b0;
        else if (pm(k) == 1) e.perr = (pbit != ones);
        else                 e.perr = (pbit != ~ones);
        e.ferr = !stops[0] || (sb(k) == 2 && !stops[1]);
        e.brk  = (d == 9'd0) && (pm(k) == 0 || !pbit) && !stops[0];
        return e;
    endfunction

    task automatic chk(input string name, input int k, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (clk_bd !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic drive_bit(input int k, input logic b, input logic spike);
        int mid;
        mid = os(k) / 2;
        rx_v[k] = b;
        if (spike) begin
            wait_ticks(mid + 1);
            rx_v[k] = ~b;
            wait_ticks(1);
            rx_v[k] = b;
            wait_ticks(os(k) - mid - 2);
        end else begin
            wait_ticks(os(k));
        end
    endtask

    task automatic send_frame(input int k, input logic [8:0] data, input logic pbit,
                              input logic [1:0] stops, input logic spike);
        q[k].push_back(model(k, data, pbit, stops));
        drive_bit(k, 1'b0, 1'b0);
        for (int i = 0; i < db(k); i++) drive_bit(k, data[i], spike && (i == 2));
        if (pm(k) != 0) drive_bit(k, pbit, 1'b0);
        for (int i = 0; i < sb(k); i++) drive_bit(k, stops[i], 1'b0);
        rx_v[k] = 1'b1;
    endtask

    task automatic rand_stream(input int k, input int n);
        logic [8:0] d;
        logic       p;
        logic       sp;
        for (int i = 0; i < n; i++) begin
            d  = 9'($urandom);
            p  = good_par(k, d) ^ ($urandom_range(0, 4) == 0);
            sp = ($urandom_range(0, 3) == 0);
            send_frame(k, d, p, 2'b11, sp);
            wait_ticks(os(k) * $urandom_range(0, 2));
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_dataout"}, k, dout_of(k), 9'd0);
            chk({tag, "_rdsig"}, k, 9'(rd_v[k]), 9'd0);
            chk({tag, "_dataerror"}, k, 9'(de_v[k]), 9'd0);
            chk({tag, "_frameerror"}, k, 9'(fe_v[k]), 9'd0);
            chk({tag, "_brk"}, k, 9'(bk_v[k]), 9'd0);
            chk({tag, "_busy"}, k, 9'(bs_v[k]), 9'd0);
        end
    endtask

    // Baud tick: one clk wide, every fourth clk
    initial begin
        clk_bd = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            clk_bd = 1'b1;
            @(negedge clk);
            clk_bd = 1'b0;
        end
    end

    // Monitor: every rdsig pops one expected frame
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            for (int k = 0; k < 4; k++) begin
                if (rd_v[k]) begin
                    chk("rdsig_width", k, 9'(prev_rd[k]), 9'd0);
                    if (q[k].size() == 0) begin
                        chk("unexpected_rdsig", k, 9'(rd_v[k]), 9'd0);
                    end else begin
                        e = q[k].pop_front();
                        chk("dataout", k, dout_of(k), e.data);
                        chk("dataerror", k, 9'(de_v[k]), 9'(e.perr));
                        chk("frameerror", k, 9'(fe_v[k]), 9'(e.ferr));
                        chk("brk", k, 9'(bk_v[k]), 9'(e.brk));
                        chk("busy_at_rdsig", k, 9'(bs_v[k]), 9'(e.brk));
                    end
                end
            end
        end
        prev_rd = rd_v;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rx_v  = '1;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        wait_ticks(4);

        // Clean frame, parity-correct frames, stop-bit-2 error
        fork
            send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b0);
            send_frame(1, 9'h003, 1'b0, 2'b11, 1'b0);
            send_frame(2, 9'h003, 1'b0, 2'b11, 1'b0);
            send_frame(3, 9'h055, 1'b0, 2'b01, 1'b0);
        join
        wait_ticks(32);

        // Parity flipped, mid-bit spike, back-to-back frames
        fork
            send_frame(0, 9'h0FF, 1'b0, 2'b11, 1'b1);
            send_frame(1, 9'h003, 1'b1, 2'b11, 1'b0);
            send_frame(2, 9'h003, 1'b1, 2'b11, 1'b0);
            begin
                send_frame(3, 9'h02A, 1'b0, 2'b11, 1'b0);
                send_frame(3, 9'h07F, 1'b0, 2'b11, 1'b0);
            end
        join
        wait_ticks(32);

        // Glitch shorter than half a bit
        rx_v[0] = 1'b0;
        wait_ticks(5);
        chk("glitch_busy_high", 0, 9'(bs_v[0]), 9'd1);
        rx_v[0] = 1'b1;
        wait_ticks(16);
        chk("glitch_busy_low", 0, 9'(bs_v[0]), 9'd0);
        wait_ticks(16);

        // Line held low for three frame times
        q[0].push_back(model(0, 9'h000, 1'b0, 2'b00));
        rx_v[0] = 1'b0;
        wait_ticks(3 * 10 * 16);
        chk("break_busy_held", 0, 9'(bs_v[0]), 9'd1);
        rx_v[0] = 1'b1;
        wait_ticks(3);
        chk("break_busy_released", 0, 9'(bs_v[0]), 9'd0);
        wait_ticks(16);
        send_frame(0, 9'h05A, 1'b0, 2'b11, 1'b0);
        wait_ticks(16);

        // Reset during data bit 4 of a frame
        drive_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, ((i % 2) == 0) ? 1'b1 : 1'b0, 1'b0);
        wait_ticks(8);
        chk("busy_before_reset", 0, 9'(bs_v[0]), 9'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_outputs_zero("midreset");
        rst_n   = 1'b1;
        rx_v[0] = 1'b1;
        wait_ticks(32);
        send_frame(0, 9'h0C3, 1'b0, 2'b11, 1'b0);
        wait_ticks(16);

        fork
            rand_stream(0, 20);
            rand_stream(1, 20);
            rand_stream(2, 20);
            rand_stream(3, 20);
        join
        wait_ticks(40);

        for (int k = 0; k < 4; k++) chk("queue_drained", k, 9'(q[k].size()), 9'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8-bit/16x receiver. Configurable data width, parity mode, stop-bit count and oversample ratio. Adds majority-vote sampling, false-start rejection, break detection and a synchronous active-low reset. Sits between the board rx pin and byte consumers; clocked by the system clock and gated by the shared baud-tick strobe.

Parameters:
DATA_BITS, 8, payload bits per frame, legal 5..9, LSB first
OVERSAMPLE, 16, clk_bd ticks per bit, even, legal 8..64
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits checked, legal 1 or 2

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
clk_bd  in  1  oversample tick enable, one clk wide, OVERSAMPLE per bit period
rx  in  1  asynchronous serial line, idle high
dataout  out  DATA_BITS  last received payload
rdsig  out  1  one-clk pulse: dataout/dataerror/frameerror/brk valid
dataerror  out  1  parity error of last frame (0 when PARITY_MODE = 0)
frameerror  out  1  any checked stop bit sampled low in last frame
brk  out  1  last frame was a break condition
busy  out  1  high from start detection until return to IDLE

Behaviour:
- Reset (rst_n low at posedge clk): state IDLE, all counters 0, dataout 0, rdsig/dataerror/frameerror/brk/busy 0, both rx synchroniser flops 1.
- rx passes through a 2-flop synchroniser; all decisions use the synchronised value rxs.
- Tick counter tc advances only on cycles where clk_bd = 1; nothing in the FSM advances otherwise. MID = OVERSAMPLE/2.
- Bit sample = majority of rxs at ticks tc = MID-1, MID, MID+1 within the bit; the decision is taken on the MID+1 tick.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: on a clk_bd tick with rxs = 0 -> START, tc = 0, busy = 1.
- START: majority = 1 -> false start, return to IDLE, busy = 0, no rdsig. Majority = 0 -> wait until tc = OVERSAMPLE-1, then DATA with tc = 0, bit index 0.
- DATA: shift in DATA_BITS samples, LSB first, one per bit period. After the last bit go to PARITY if PARITY_MODE != 0, else STOP.
- PARITY: expected bit = XOR of data (even) or its inverse (odd). Mismatch sets the internal parity flag.
- STOP: sample STOP_BITS stop bits; any 0 sets the internal frame flag. Frame completes on the MID+1 tick of the final stop bit. It does not wait for the bit end, so back-to-back frames are received with no gap.
- Completion: on the next clk cycle dataout, dataerror, frameerror and brk update together and rdsig = 1 for exactly one clk. Error flags and brk hold until the next completion.
- Break: all data bits 0, parity bit 0 (if present) and first stop bit 0 -> brk = 1, frameerror = 1. FSM then enters WAIT_HIGH and stays there until a tick with rxs = 1, then goes to IDLE. busy stays high through WAIT_HIGH.
- busy falls on the same cycle rdsig rises, except after a break, where it falls on leaving WAIT_HIGH.
- Reset mid-frame: abort immediately to the reset state. No rdsig for the partial frame.
- A falling edge during STOP after the frame is complete is handled normally in IDLE. rx activity during DATA/PARITY/STOP never restarts a frame.

Test Plan:
1. Defaults, clk_bd every 4 clk, send 0xA5 with 1 stop bit -> one rdsig pulse, dataout = 0xA5, dataerror = 0, frameerror = 0, brk = 0. rdsig lands 1 clk after the MID+1 tick of the stop bit.
2. PARITY_MODE = 1: send 0x03 with parity 0 -> dataerror = 0. Send 0x03 with parity 1 -> dataerror = 1. Repeat with PARITY_MODE = 2 -> results inverted.
3. Drive rx low for 5 ticks, then high (glitch) -> FSM returns to IDLE, no rdsig, busy pulses then returns to 0. A single-tick spike at MID of a data bit is outvoted.
4. DATA_BITS = 7, STOP_BITS = 2: send 0x55 with the second stop bit low -> dataout = 0x55, frameerror = 1. Then back-to-back 0x2A and 0x7F -> two rdsig pulses, correct data.
5. Hold rx low for 3 frame times, then release -> one rdsig with dataout = 0, brk = 1, frameerror = 1. No further rdsig until rx returns high, then normal reception of 0x5A.
6. Pulse rst_n low during data bit 4 of a frame -> all outputs 0 next cycle, no rdsig. The following frame 0xC3 is received correctly.
